// File: rtl/alu_pkg.sv
// Shared definitions for the parameterised ALU.
// Contents: default operand width, opcode map, FSM state encoding,
// registered flag bundle and its reset value.
package alu_pkg;

  localparam int unsigned ALU_WIDTH_DEFAULT = 32;
  localparam int unsigned OP_W              = 4;

  // Codes 0-4 keep the encoding of the older 3-bit ALU.
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOR  = 4'h5,
    OP_SLT  = 4'h6,
    OP_SLTU = 4'h7,
    OP_SLL  = 4'h8,
    OP_SRL  = 4'h9,
    OP_SRA  = 4'hA,
    OP_MUL  = 4'hB
  } alu_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

  // A cleared result of 0 reports zero=1.
  localparam alu_flags_t FLAGS_RESET = '{zero: 1'b1, negative: 1'b0, carry: 1'b0, overflow: 1'b0};

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   clock, clear    : clock and asynchronous active-high reset (aborts a run)
//   start_i         : load operands and begin; ignored state is reloaded
//   a_i, b_i        : multiplicand / multiplier
//   done_c_o        : high in the cycle whose rising edge completes the product
//   product_c_o     : low WIDTH bits of the product, valid when done_c_o is high
// A run started on edge E0 adds its last partial product on edge E0+WIDTH;
// the product is presented combinationally so the caller can register it on
// that same edge.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_c_o,
  output logic [WIDTH-1:0] product_c_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] step_sum;
  logic             last_step;

  // Accumulator plus the current partial product.
  always_comb begin
    step_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    last_step = run_q && (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Load on start, otherwise one shift-add step per cycle while running.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_step) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

  assign done_c_o    = last_step;
  assign product_c_o = step_sum;

endmodule

// File: rtl/param_alu.sv
// Parameterised ALU: single-cycle arithmetic/logic/shift ops plus an
// iterative WIDTH-cycle multiply, with registered result and flags.
// Ports:
//   clock, clear          : clock and asynchronous active-high reset
//   start                 : request, accepted only in IDLE
//   opCode                : operation select (see alu_pkg::alu_op_e)
//   inputA, inputB        : operands; inputB low log2(WIDTH) bits = shift amount
//   result                : registered result
//   zero, negative, carry, overflow : registered flags
//   busy                  : multiply in flight
//   done                  : one-cycle completion pulse
module param_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [OP_W-1:0]  opCode,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned SUM_W = WIDTH + 1;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             is_mul;
  logic [SH_W-1:0]  shamt;
  logic [SUM_W-1:0] add_sum;
  logic [SUM_W-1:0] sub_sum;
  logic [WIDTH-1:0] alu_res;
  alu_flags_t       alu_flags;
  logic             mul_done_c;
  logic [WIDTH-1:0] mul_product_c;

  assign accept = (state_q == ST_IDLE) && start;
  assign is_mul = (opCode == OP_MUL);

  // Single-cycle datapath; the result is registered on the accepting edge.
  always_comb begin
    shamt   = inputB[SH_W-1:0];
    add_sum = {1'b0, inputA} + {1'b0, inputB};
    sub_sum = {1'b0, inputA} + {1'b0, ~inputB} + SUM_W'(1);
    alu_res = '0;
    alu_flags = '{zero: 1'b0, negative: 1'b0, carry: 1'b0, overflow: 1'b0};
    case (opCode)
      OP_ADD: begin
        alu_res            = add_sum[WIDTH-1:0];
        alu_flags.carry    = add_sum[WIDTH];
        alu_flags.overflow = (inputA[WIDTH-1] == inputB[WIDTH-1]) &&
                             (add_sum[WIDTH-1] != inputA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res            = sub_sum[WIDTH-1:0];
        alu_flags.carry    = sub_sum[WIDTH];
        alu_flags.overflow = (inputA[WIDTH-1] != inputB[WIDTH-1]) &&
                             (sub_sum[WIDTH-1] != inputA[WIDTH-1]);
      end
      OP_AND:  alu_res = inputA & inputB;
      OP_OR:   alu_res = inputA | inputB;
      OP_XOR:  alu_res = inputA ^ inputB;
      OP_NOR:  alu_res = ~(inputA | inputB);
      OP_SLT:  alu_res = WIDTH'($signed(inputA) < $signed(inputB));
      OP_SLTU: alu_res = WIDTH'(inputA < inputB);
      OP_SLL:  alu_res = inputA << shamt;
      OP_SRL:  alu_res = inputA >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(inputA) >>> shamt);
      default: alu_res = '0;  // MUL handled by the sub-module; C-F reserved
    endcase
    alu_flags.zero     = (alu_res == '0);
    alu_flags.negative = alu_res[WIDTH-1];
  end

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clock       (clock),
    .clear       (clear),
    .start_i     (accept && is_mul),
    .a_i         (inputA),
    .b_i         (inputB),
    .done_c_o    (mul_done_c),
    .product_c_o (mul_product_c)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
      ST_MUL:  if (mul_done_c)       state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; result and flags hold unless an operation completes.
  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            busy_d = 1'b1;
          end else begin
            result_d = alu_res;
            flags_d  = alu_flags;
            done_d   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done_c) begin
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = mul_product_c;
          flags_d  = '{zero: (mul_product_c == '0), negative: mul_product_c[WIDTH-1],
                       carry: 1'b0, overflow: 1'b0};
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= FLAGS_RESET;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result   = result_q;
  assign zero     = flags_q.zero;
  assign negative = flags_q.negative;
  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_param_alu.sv
// Directed and randomized checks of param_alu (WIDTH=32) against a
// behavioural arithmetic model.
module tb_param_alu;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic [3:0]   opCode;
  logic [W-1:0] inputA;
  logic [W-1:0] inputB;
  logic [W-1:0] result;
  logic         zero, negative, carry, overflow, busy, done;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_res;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z, n, c, v;
  } exp_t;

  param_alu #(.WIDTH(W)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .opCode   (opCode),
    .inputA   (inputA),
    .inputB   (inputB),
    .result   (result),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint unsigned u;
    longint s;
    int unsigned sh;
    sh = int'(b % 32);
    e = '0;
    case (op)
      4'h0: begin
        u = 64'(a) + 64'(b);
        e.r = u[31:0];
        e.c = u[32];
        s = longint'($signed(a)) + longint'($signed(b));
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h1: begin
        e.r = a - b;
        e.c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h2: e.r = a & b;
      4'h3: e.r = a | b;
      4'h4: e.r = a ^ b;
      4'h5: e.r = ~(a | b);
      4'h6: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h7: e.r = (a < b) ? 32'd1 : 32'd0;
      4'h8: e.r = a << sh;
      4'h9: e.r = a >> sh;
      4'hA: e.r = $unsigned($signed(a) >>> sh);
      4'hB: begin
        u = 64'(a) * 64'(b);
        e.r = u[31:0];
      end
      default: e.r = '0;
    endcase
    e.z = (e.r == 0);
    e.n = e.r[31];
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one op; returns in the done cycle so a following call is back-to-back.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag, input bit pulse_mid);
    exp_t e;
    int bad;
    e = model(op, a, b);
    opCode = op; inputA = a; inputB = b; start = 1'b1;
    step();
    start = 1'b0;
    inputA = $urandom; inputB = $urandom;
    if (op == 4'hB) begin
      check({tag, " busy0"}, 64'(busy), 64'd1);
      check({tag, " done0"}, 64'(done), 64'd0);
      bad = 0;
      for (int k = 1; k < 32; k++) begin
        if (pulse_mid && k == 5) begin
          start = 1'b1; opCode = 4'h0;
        end
        step();
        start = 1'b0;
        if (busy !== 1'b1 || done !== 1'b0 || result !== last_res) bad++;
      end
      check({tag, " inflight"}, 64'(bad), 64'd0);
      step();
    end
    check({tag, " result"}, 64'(result), 64'(e.r));
    check({tag, " flags"}, 64'({zero, negative, carry, overflow}), 64'({e.z, e.n, e.c, e.v}));
    check({tag, " done"}, 64'({done, busy}), 64'b10);
    last_res = e.r;
  endtask

  task automatic idle_check(input string tag);
    start = 1'b0;
    step();
    check({tag, " idle"}, 64'({done, busy, result}), {30'd0, 2'b00, last_res});
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    int           dones;

    clear = 1'b1; start = 1'b0; opCode = '0; inputA = '0; inputB = '0;
    last_res = '0;
    step();
    step();
    check("reset result", 64'(result), 64'd0);
    check("reset flags", 64'({zero, negative, carry, overflow}), 64'b1000);
    check("reset busy/done", 64'({busy, done}), 64'd0);
    #2 clear = 1'b0;

    run_op(4'h0, 32'd805, 32'd302, "add", 1'b0);
    idle_check("after add");
    run_op(4'h1, 32'd805, 32'd805, "sub_eq", 1'b0);
    run_op(4'h1, 32'd805, 32'd302, "sub", 1'b0);
    run_op(4'h0, 32'h7FFF_FFFF, 32'd1, "add_ovf", 1'b0);
    run_op(4'hA, 32'h8000_0000, 32'd4, "sra4", 1'b0);
    run_op(4'hA, 32'h8123_4567, 32'd0, "sra0", 1'b0);
    run_op(4'h2, 32'd805, 32'd302, "and", 1'b0);
    run_op(4'h3, 32'd805, 32'd302, "or", 1'b0);
    run_op(4'h4, 32'd805, 32'd302, "xor", 1'b0);
    run_op(4'hD, 32'd805, 32'd302, "rsvd", 1'b0);
    run_op(4'h6, 32'hFFFF_FFFF, 32'd1, "slt", 1'b0);
    run_op(4'h7, 32'hFFFF_FFFF, 32'd1, "sltu", 1'b0);
    run_op(4'hB, 32'd805, 32'd302, "mul", 1'b1);
    run_op(4'h0, 32'd1, 32'd2, "b2b", 1'b0);
    idle_check("after b2b");

    // Abort a multiply with clear in its tenth cycle.
    opCode = 4'hB; inputA = 32'd805; inputB = 32'd302; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    #2 clear = 1'b1;
    #1;
    check("clr result", 64'(result), 64'd0);
    check("clr flags", 64'({zero, busy, done}), 64'b100);
    #2 clear = 1'b0;
    last_res = '0;
    run_op(4'h0, 32'd805, 32'd302, "add_after_clr", 1'b0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done === 1'b1) dones++;
    end
    check("no late done", 64'(dones), 64'd0);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) b = a;
      if (i % 5 == 0) b = 32'($urandom_range(0, 40));
      if (i % 6 == 0) a = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
      run_op(op, a, b, $sformatf("rnd%0d_op%0h", i, op), 1'b0);
      if (i % 7 == 0) idle_check("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
